// File: rtl/ifu_fetch_ctrl.sv
// RV32 instruction-fetch front end: owns the fetch PC, issues imem requests, buffers responses for decode.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
// state | meaning
// BOOT  | single idle cycle after reset, no request
// FETCH | normal sequential issue under the credit limit
// FLUSH | discarding stale responses left over from a redirect
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int              PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PW-1:0]   LAST_IDX = PW'(BUF_DEPTH - 1);
    localparam logic [3:0]      DEPTH_C  = 4'(BUF_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [3:0]    out_cnt_q, out_cnt_d;
    logic [3:0]    buf_cnt_q, buf_cnt_d;
    logic [3:0]    drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [31:0]   pend_pc_q   [BUF_DEPTH];
    logic [31:0]   pend_pc_d   [BUF_DEPTH];
    logic [31:0]   buf_pc_q    [BUF_DEPTH];
    logic [31:0]   buf_pc_d    [BUF_DEPTH];
    logic [31:0]   buf_instr_q [BUF_DEPTH];
    logic [31:0]   buf_instr_d [BUF_DEPTH];

    logic issue, rsp_keep, rsp_drop, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Credit counts both in-flight requests and buffered instructions, so responses never overflow.
    assign imem_req_valid = (state_q == FETCH) && !redirect_valid
                            && ((out_cnt_q + buf_cnt_q) < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && !redirect_valid && (state_q != FLUSH);
    assign rsp_drop       = imem_rsp_valid && !rsp_keep;
    assign if_valid       = (buf_cnt_q != 4'd0);
    assign pop            = if_valid && if_ready && !redirect_valid;

    assign if_instr   = if_valid ? buf_instr_q[buf_rd_q] : '0;
    assign if_pc      = if_valid ? buf_pc_q[buf_rd_q] : '0;
    assign if_pcplus4 = if_valid ? (buf_pc_q[buf_rd_q] + 32'd4) : '0;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_cnt_d   = out_cnt_q;
        buf_cnt_d   = buf_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        pend_wr_d   = pend_wr_q;
        pend_rd_d   = pend_rd_q;
        buf_wr_d    = buf_wr_q;
        buf_rd_d    = buf_rd_q;
        pend_pc_d   = pend_pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;

        if (issue) begin
            pc_d                 = pc_q + 32'd4;
            pend_pc_d[pend_wr_q] = pc_q;
            pend_wr_d            = ptr_inc(pend_wr_q);
        end
        if (issue && !imem_rsp_valid) begin
            out_cnt_d = out_cnt_q + 4'd1;
        end else if (!issue && imem_rsp_valid) begin
            out_cnt_d = out_cnt_q - 4'd1;
        end

        if (rsp_keep) begin
            buf_pc_d[buf_wr_q]    = pend_pc_q[pend_rd_q];
            buf_instr_d[buf_wr_q] = imem_rsp_data;
            buf_wr_d              = ptr_inc(buf_wr_q);
            pend_rd_d             = ptr_inc(pend_rd_q);
        end
        if (pop) begin
            buf_rd_d = ptr_inc(buf_rd_q);
        end
        if (rsp_keep && !pop) begin
            buf_cnt_d = buf_cnt_q + 4'd1;
        end else if (!rsp_keep && pop) begin
            buf_cnt_d = buf_cnt_q - 4'd1;
        end

        case (state_q)
            BOOT: state_d = FETCH;
            FLUSH: begin
                if (rsp_drop && (drop_cnt_q != 4'd0)) begin
                    drop_cnt_d = drop_cnt_q - 4'd1;
                end
                if (drop_cnt_d == 4'd0) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // Redirect wins over everything; the pending-PC FIFO restarts empty since stale entries are only counted.
        if (redirect_valid) begin
            pc_d       = redirect_pc & 32'hFFFF_FFFC;
            buf_cnt_d  = 4'd0;
            buf_rd_d   = '0;
            buf_wr_d   = '0;
            pend_rd_d  = '0;
            pend_wr_d  = '0;
            drop_cnt_d = out_cnt_d;
            state_d    = (out_cnt_d != 4'd0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            out_cnt_q  <= 4'd0;
            buf_cnt_q  <= 4'd0;
            drop_cnt_q <= 4'd0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pend_pc_q[i]   <= '0;
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_cnt_q   <= out_cnt_d;
            buf_cnt_q   <= buf_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            pend_wr_q   <= pend_wr_d;
            pend_rd_q   <= pend_rd_d;
            buf_wr_q    <= buf_wr_d;
            buf_rd_q    <= buf_rd_d;
            pend_pc_q   <= pend_pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d, perf_drop_q, perf_drop_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, issue};
        perf_drop_d  = perf_drop_q + {31'd0, rsp_drop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl (RESET_PC=0x100, BUF_DEPTH=2) with a small in-order imem responder.
// Perf counter checks are compiled in when IFU_PERF_CNT_EN is defined.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    ifu_fetch_ctrl #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pcplus4     (if_pcplus4)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // imem model: instruction word is 0xC0DE in the top half and the low address half below it.
    int          cyc = 0;
    int          rsp_lat = 1;
    int          due_q[$];
    logic [31:0] raddr_q[$];

    always @(posedge clk) begin
        if (reset) begin
            due_q.delete();
            raddr_q.delete();
        end else begin
            if (imem_rsp_valid && due_q.size() > 0) begin
                void'(due_q.pop_front());
                void'(raddr_q.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                due_q.push_back(cyc + rsp_lat);
                raddr_q.push_back(imem_req_addr);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!reset && due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {16'hC0DE, raddr_q[0][15:0]};
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ifv(input string tag);
        for (int i = 0; i < 40 && !if_valid; i++) step();
        chk(tag, {31'd0, if_valid}, 32'd1);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0100);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pcplus4", if_pcplus4, 32'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          acc;
        int          rsps;
        int          stale;
        int          leak;
        logic [31:0] exp_pc;

        // Sequential stream after reset
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        rsp_lat        = 1;
        do_reset();
        chk("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
        step();
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0000_0100);
        step();
        step();
        chk("lat_if_valid", {31'd0, if_valid}, 32'd1);
        chk("lat_if_pc", if_pc, 32'h0000_0100);
        exp_pc = 32'h0000_0100;
        n = 0;
        for (int i = 0; i < 60 && n < 6; i++) begin
            if (if_valid) begin
                chk("stream_pc", if_pc, exp_pc);
                chk("stream_pcplus4", if_pcplus4, exp_pc + 32'd4);
                chk("stream_instr", if_instr, {16'hC0DE, exp_pc[15:0]});
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            step();
        end
        chk("stream_count", 32'(n), 32'd6);

        // Decode backpressure from reset: only two requests fit
        if_ready = 1'b0;
        do_reset();
        acc = 0;
        repeat (9) begin
            if (imem_req_valid && imem_req_ready) acc++;
            step();
        end
        chk("bp_req_count", 32'(acc), 32'd2);
        chk("bp_head_valid", {31'd0, if_valid}, 32'd1);
        chk("bp_head_pc", if_pc, 32'h0000_0100);
        if_ready = 1'b1;
        exp_pc = 32'h0000_0100;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            if (if_valid) begin
                chk("drain_pc", if_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            step();
        end
        chk("drain_count", 32'(n), 32'd4);

        // Ten fetches, then redirect with two requests in flight
        rsp_lat = 4;
        do_reset();
        acc  = 0;
        rsps = 0;
        for (int i = 0; i < 300; i++) begin
            if (acc == 10 && (acc - rsps) == 2) break;
            if (imem_req_valid && imem_req_ready) acc++;
            if (imem_rsp_valid) rsps++;
            step();
        end
        chk("ten_fetched", 32'(acc), 32'd10);
        chk("two_in_flight", 32'(acc - rsps), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        #1;
        chk("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
        stale = imem_rsp_valid ? 1 : 0;
        leak  = 0;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("flush_addr", imem_req_addr, 32'h0000_2000);
        for (int i = 0; i < 40 && !imem_req_valid; i++) begin
            if (imem_rsp_valid) stale++;
            if (if_valid) leak++;
            step();
        end
        chk("reissue_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("reissue_addr", imem_req_addr, 32'h0000_2000);
        chk("stale_discarded", 32'(stale), 32'd2);
        chk("stale_leaked", 32'(leak), 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd10);
        chk("perf_drop", perf_drop_cnt, 32'd2);
`endif
        wait_ifv("redir_if_valid");
        chk("redir_if_pc", if_pc, 32'h0000_2000);
        chk("redir_if_instr", if_instr, 32'hC0DE_2000);

        // PC wrap at the top of the address space
        rsp_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        #1;
        wait_ifv("wrap_if_valid0");
        chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pcplus4_0", if_pcplus4, 32'h0000_0000);
        chk("wrap_instr0", if_instr, 32'hC0DE_FFFC);
        step();
        wait_ifv("wrap_if_valid1");
        chk("wrap_pc1", if_pc, 32'h0000_0000);
        chk("wrap_pcplus4_1", if_pcplus4, 32'h0000_0004);

        // imem not ready: request held stable, then dropped by redirect
        imem_req_ready = 1'b0;
        do_reset();
        step();
        repeat (3) begin
            chk("hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("hold_addr", imem_req_addr, 32'h0000_0100);
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        #1;
        chk("hold_redir_drop", {31'd0, imem_req_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("hold_new_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("hold_new_addr", imem_req_addr, 32'h0000_3000);
        imem_req_ready = 1'b1;
        wait_ifv("hold_if_valid");
        chk("hold_if_pc", if_pc, 32'h0000_3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
